// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//
// Successive-approximation controller for the tile's ADC/DAC macro. It drives
// the track/hold switch and the R-2R DAC trial code, reads back the comparator
// through a 2-flop synchroniser, and binary-searches one WIDTH-bit code per
// start request.
//
// Optional feature (compile-time macro SAR_AVG_EN):
//   defined   - one start runs 4 back-to-back conversions; the reported result
//               is the truncated mean of the 4 codes.
//   undefined - one conversion per start; no accumulator hardware.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset (deassertion synchronised)
//   start        in   conversion request, sampled on clk
//   comp_in      in   asynchronous comparator output, 1 = Vin >= Vdac
//   sample_en    out  track/hold enable, high for SAMPLE_CYCLES per conversion
//   dac_code     out  trial code to the DAC (last result while idle)
//   busy         out  conversion in progress
//   done         out  single-cycle pulse when result updates
//   result       out  last completed conversion
//   result_valid out  result is a completed conversion not yet superseded
//
// Handshake: start is accepted on a rising clk edge while the controller is
// idle or in its final (done) cycle; busy rises in the next cycle and stays
// high until the cycle after the done pulse, unless start restarts it.
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
   parameter int WIDTH         = 8,
   parameter int SAMPLE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             comp_in,
   output logic             sample_en,
   output logic [WIDTH-1:0] dac_code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             result_valid
);

   // Each bit spends SETTLE_CYCLES of analog settling plus the two
   // synchroniser stages before comp_s reflects the current trial code.
   localparam int BIT_CYCLES = SETTLE_CYCLES + 2;
   localparam int IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [7:0]       SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);
   localparam logic [4:0]       SETTLE_LOAD = 5'(BIT_CYCLES - 1);
   localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [IW-1:0]    TOP_IDX     = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_BIT    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // ---------------------------------------------------------------------------
   // Reset: asserts immediately, releases two clocks after rst_n rises.
   // ---------------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_n_int;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign rst_n_int = rst_sync_q[1];

   // ---------------------------------------------------------------------------
   // Comparator synchroniser
   // ---------------------------------------------------------------------------
   logic comp_meta_q;
   logic comp_s;

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         comp_meta_q <= 1'b0;
         comp_s      <= 1'b0;
      end else begin
         comp_meta_q <= comp_in;
         comp_s      <= comp_meta_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Controller state
   // ---------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [WIDTH-1:0] code_q, code_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic [7:0]       sample_cnt_q, sample_cnt_d;
   logic [4:0]       settle_cnt_q, settle_cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;

   logic [WIDTH-1:0] code_eval;   // code with the current bit decided
   logic [WIDTH-1:0] code_step;   // code_eval with the next trial bit set
   logic             launch;      // begin a SAMPLE phase next cycle
   logic             new_request; // launch caused by a host start

`ifdef SAR_AVG_EN
   logic [WIDTH+1:0] acc_q, acc_d;
   logic [1:0]       avg_cnt_q, avg_cnt_d;
   logic [WIDTH+1:0] acc_sum;
`endif

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q        <= ST_IDLE;
         code_q         <= '0;
         bit_idx_q      <= '0;
         sample_cnt_q   <= '0;
         settle_cnt_q   <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
`ifdef SAR_AVG_EN
         acc_q          <= '0;
         avg_cnt_q      <= '0;
`endif
      end else begin
         state_q        <= state_d;
         code_q         <= code_d;
         bit_idx_q      <= bit_idx_d;
         sample_cnt_q   <= sample_cnt_d;
         settle_cnt_q   <= settle_cnt_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
`ifdef SAR_AVG_EN
         acc_q          <= acc_d;
         avg_cnt_q      <= avg_cnt_d;
`endif
      end
   end

   always_comb begin
      state_d        = state_q;
      code_d         = code_q;
      bit_idx_d      = bit_idx_q;
      sample_cnt_d   = sample_cnt_q;
      settle_cnt_d   = settle_cnt_q;
      result_d       = result_q;
      result_valid_d = result_valid_q;
      launch         = 1'b0;
      new_request    = 1'b0;

      code_eval            = code_q;
      code_eval[bit_idx_q] = comp_s;
      // When bit_idx_q is 0 this index wraps; code_step is unused then.
      code_step                        = code_eval;
      code_step[bit_idx_q - IW'(1)]    = 1'b1;

`ifdef SAR_AVG_EN
      acc_d     = acc_q;
      avg_cnt_d = avg_cnt_q;
      acc_sum   = acc_q + {2'b00, code_eval};
`endif

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               launch      = 1'b1;
               new_request = 1'b1;
            end
         end

         ST_SAMPLE: begin
            if (sample_cnt_q == 8'd0) begin
               state_d      = ST_BIT;
               code_d       = MSB_CODE;
               bit_idx_d    = TOP_IDX;
               settle_cnt_d = SETTLE_LOAD;
            end else begin
               sample_cnt_d = sample_cnt_q - 8'd1;
            end
         end

         ST_BIT: begin
            if (settle_cnt_q == 5'd0) begin
               if (bit_idx_q != '0) begin
                  code_d       = code_step;
                  bit_idx_d    = bit_idx_q - IW'(1);
                  settle_cnt_d = SETTLE_LOAD;
               end else begin
                  code_d  = code_eval;
                  state_d = ST_DONE;
`ifdef SAR_AVG_EN
                  acc_d = acc_sum;
                  if (avg_cnt_q == 2'd3) begin
                     result_d       = acc_sum[WIDTH+1:2];
                     result_valid_d = 1'b1;
                  end
`else
                  result_d       = code_eval;
                  result_valid_d = 1'b1;
`endif
               end
            end else begin
               settle_cnt_d = settle_cnt_q - 5'd1;
            end
         end

         ST_DONE: begin
`ifdef SAR_AVG_EN
            // Intermediate passes chain straight into the next sample phase.
            if (avg_cnt_q != 2'd3) begin
               launch = 1'b1;
            end else if (start) begin
               launch      = 1'b1;
               new_request = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
`else
            if (start) begin
               launch      = 1'b1;
               new_request = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
`endif
         end

         default: state_d = ST_IDLE;
      endcase

      if (launch) begin
         state_d      = ST_SAMPLE;
         code_d       = '0;
         sample_cnt_d = SAMPLE_LOAD;
      end

      if (new_request) begin
         result_valid_d = 1'b0;
`ifdef SAR_AVG_EN
         acc_d     = '0;
         avg_cnt_d = '0;
`endif
      end
`ifdef SAR_AVG_EN
      else if (launch) begin
         avg_cnt_d = avg_cnt_q + 2'd1;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // Outputs (all decoded from registers; zero in reset)
   // ---------------------------------------------------------------------------
   assign sample_en    = (state_q == ST_SAMPLE);
   assign busy         = (state_q != ST_IDLE);
   assign dac_code     = code_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
`ifdef SAR_AVG_EN
   assign done = (state_q == ST_DONE) && (avg_cnt_q == 2'd3);
`else
   assign done = (state_q == ST_DONE);
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//
// Drives sar_adc_ctrl with an ideal comparator model (comp_in = vin >= dac_code,
// replaced by random noise while the track/hold is open). Expected results
// and done times come from the reference model: an ideal SAR returns vin, and
// the trial code for step j is the top j bits of vin plus the next trial bit.
// -----------------------------------------------------------------------------
module tb_sar_adc_ctrl;

   localparam int WIDTH  = 8;
   localparam int S      = 4;
   localparam int SETTLE = 2;
   localparam int W      = SETTLE + 2;
   localparam int CONV   = S + WIDTH * W;
`ifdef SAR_AVG_EN
   localparam int LAT = 4 * (CONV + 1) - 1;
`else
   localparam int LAT = CONV;
`endif

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             comp_in;
   logic             sample_en;
   logic [WIDTH-1:0] dac_code;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             result_valid;

   logic [WIDTH-1:0] vin = '0;
   logic             glitch = 1'b0;
   int               cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) glitch = 1'($urandom_range(0, 1));

   assign comp_in = sample_en ? glitch : (vin >= dac_code);

   sar_adc_ctrl #(
      .WIDTH        (WIDTH),
      .SAMPLE_CYCLES(S),
      .SETTLE_CYCLES(SETTLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .comp_in     (comp_in),
      .sample_en   (sample_en),
      .dac_code    (dac_code),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .result_valid(result_valid)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] exp_q[$];
   int               exp_cyc_q[$];
   int               n_pass = 0;
   int               n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [WIDTH-1:0] trial_code(input logic [WIDTH-1:0] v, input int j);
      int vi, hi;
      vi = int'(v);
      hi = (vi >> (WIDTH - j)) << (WIDTH - j);
      return WIDTH'(hi + (1 << (WIDTH - 1 - j)));
   endfunction

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [WIDTH-1:0] er;
            int               ec;
            er = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            check("result", 32'(result), 32'(er));
            check("done_cycle", 32'(cyc), 32'(ec));
            check("result_valid_at_done", 32'(result_valid), 32'd1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic check_all_zero(input string tag);
      check({tag, "_sample_en"}, 32'(sample_en), 32'd0);
      check({tag, "_dac_code"}, 32'(dac_code), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_result"}, 32'(result), 32'd0);
      check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
   endtask

   // Waits (bounded) for the done pulse; leaves the caller at that negedge.
   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k <= budget && !seen; k++) begin
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         exp_q.delete();
         exp_cyc_q.delete();
      end
   endtask

   task automatic run_conv(input logic [WIDTH-1:0] v, input bit detail, input bit noisy);
      int c;
      bit seen;
      @(negedge clk);
      vin   = v;
      start = 1'b1;
      c     = cyc;
      exp_q.push_back(v);
      exp_cyc_q.push_back(c + 1 + LAT);
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      // Here cyc = E0 + k: the cycle following edge E0 + k.
      for (int k = 0; k <= LAT + 8 && !seen; k++) begin
         if (detail) begin
            if (k <= S) check("sample_en_window", 32'(sample_en), (k < S) ? 32'd1 : 32'd0);
            if (k < S) check("dac_code_in_sample", 32'(dac_code), 32'd0);
            if (k >= S && k < CONV && ((k - S) % W) == 0)
               check("trial_code", 32'(dac_code), 32'(trial_code(v, (k - S) / W)));
         end
         if (done) begin
            seen = 1'b1;
         end else begin
            start = noisy && (k < LAT - 2) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
         end
      end
      start = 1'b0;
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
      check("busy_after_done", 32'(busy), 32'd0);
      check("valid_after_done", 32'(result_valid), 32'd1);
      check("dac_holds_result", 32'(dac_code), 32'(v));
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic reset_mid_conversion(input logic [WIDTH-1:0] v);
      @(negedge clk);
      vin   = v;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      // Land inside the fifth trial (bit index 3).
      repeat (S + 4 * W + 1) @(negedge clk);
      check("busy_before_reset", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_reset");
      exp_q.delete();
      exp_cyc_q.delete();
      release_reset();
      check_all_zero("after_mid_reset");
   endtask

   task automatic held_start(input logic [WIDTH-1:0] v0, input logic [WIDTH-1:0] v1);
      int c;
      bit seen;
      @(negedge clk);
      vin   = v0;
      start = 1'b1;
      c     = cyc;
      exp_q.push_back(v0);
      exp_cyc_q.push_back(c + 1 + LAT);
      exp_q.push_back(v1);
      exp_cyc_q.push_back(c + 1 + LAT + LAT + 1);
      wait_done(LAT + 8, seen);
      vin = v1;
      @(negedge clk);
      start = 1'b0;
      check("busy_back_to_back", 32'(busy), 32'd1);
      wait_done(LAT + 8, seen);
      @(negedge clk);
      check("busy_after_second", 32'(busy), 32'd0);
   endtask

`ifdef SAR_AVG_EN
   task automatic avg_sequence();
      logic [WIDTH-1:0] seq[4];
      int               sum, c;
      bit               seen;
      seq = '{8'h10, 8'h11, 8'h12, 8'h14};
      sum = 0;
      foreach (seq[m]) sum += int'(seq[m]);
      @(negedge clk);
      vin   = seq[0];
      start = 1'b1;
      c     = cyc;
      exp_q.push_back(WIDTH'(sum / 4));
      exp_cyc_q.push_back(c + 1 + LAT);
      @(negedge clk);
      start = 1'b0;
      seen  = 1'b0;
      for (int k = 0; k <= LAT + 8 && !seen; k++) begin
         if (k > 0 && k % (CONV + 1) == 0 && k / (CONV + 1) < 4) vin = seq[k / (CONV + 1)];
         if (k < LAT) check("avg_busy", 32'(busy), 32'd1);
         if (done) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         check("done_timeout", 32'd0, 32'd1);
         exp_q.delete();
         exp_cyc_q.delete();
      end
      @(negedge clk);
   endtask
`endif

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      release_reset();
      check_all_zero("after_reset");

      run_conv(8'hA5, 1'b1, 1'b0);
      run_conv(8'h00, 1'b1, 1'b0);
      run_conv(8'hFF, 1'b1, 1'b0);
      run_conv(8'h6B, 1'b1, 1'b1);

      reset_mid_conversion(8'h5A);
      run_conv(8'h3C, 1'b1, 1'b0);

      held_start(8'h10, 8'hE7);

`ifdef SAR_AVG_EN
      avg_sequence();
`endif

      for (int n = 0; n < 12; n++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_conv(WIDTH'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, %0d/%0d checks passed",
               n_pass, n_total);
      $fatal(1, "global timeout");
   end

endmodule
